// File: rtl/csr_trap_ctrl.sv
// Machine-mode trap sequencer: writes mepc/mcause/mtval/mstatus (or mstatus for mret) one per cycle, then redirects.
// Optional: define CSR_TRAP_VECTORED_EN to vector interrupts to base + 4*code when mtvec.MODE == 2'b01.
module csr_trap_ctrl #(
  parameter int         XLEN     = 64,
  parameter int         EXC_W    = 4,
  parameter logic [1:0] MRET_MPP = 2'b00
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             commit_valid,
  input  logic [XLEN-1:0]  commit_pc,
  input  logic             commit_exc,
  input  logic [EXC_W-1:0] commit_cause,
  input  logic [XLEN-1:0]  commit_tval,
  input  logic             commit_mret,
  input  logic             trint,
  input  logic             swint,
  input  logic             exint,
  input  logic [XLEN-1:0]  mstatus_i,
  input  logic [XLEN-1:0]  mie_i,
  input  logic [XLEN-1:0]  mtvec_i,
  input  logic [XLEN-1:0]  mepc_i,
  output logic             csr_we,
  output logic [11:0]      csr_waddr,
  output logic [XLEN-1:0]  csr_wdata,
  output logic             stall,
  output logic             redirect_valid,
  output logic [XLEN-1:0]  redirect_pc
);

  typedef enum logic [2:0] {
    IDLE,
    W_MEPC,
    W_MCAUSE,
    W_MTVAL,
    W_MSTATUS,
    M_STATUS,
    REDIRECT
  } state_t;

  localparam logic [11:0] ADDR_MSTATUS = 12'h300;
  localparam logic [11:0] ADDR_MEPC    = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE  = 12'h342;
  localparam logic [11:0] ADDR_MTVAL   = 12'h343;

  state_t          state;
  logic [XLEN-1:0] cause_q;
  logic [XLEN-1:0] tval_q;
  logic [XLEN-1:0] mstatus_q;
  logic [XLEN-1:0] mtvec_q;
  logic [XLEN-1:0] mepc_q;

  logic            pend_e, pend_s, pend_t;
  logic            int_take;
  logic [3:0]      int_code;
  logic            accept_exc, accept_mret, accept_int;
  logic [XLEN-1:0] exc_cause;
  logic [XLEN-1:0] int_cause;
  logic [XLEN-1:0] trap_status;
  logic [XLEN-1:0] mret_status;
  logic [XLEN-1:0] trap_target;
  logic            unused_bits;

  // Event selection: exception beats mret, which beats any interrupt (external > software > timer).
  always_comb begin
    pend_e   = exint & mie_i[11];
    pend_s   = swint & mie_i[3];
    pend_t   = trint & mie_i[7];
    int_code = 4'd0;
    if (pend_e)      int_code = 4'd11;
    else if (pend_s) int_code = 4'd3;
    else if (pend_t) int_code = 4'd7;
    int_take    = mstatus_i[3] & (pend_e | pend_s | pend_t);
    accept_exc  = commit_valid & commit_exc;
    accept_mret = commit_valid & ~commit_exc & commit_mret;
    accept_int  = commit_valid & ~commit_exc & ~commit_mret & int_take;

    exc_cause = {{(XLEN-EXC_W){1'b0}}, commit_cause};
    int_cause = {{(XLEN-4){1'b0}}, int_code};
    int_cause[XLEN-1] = 1'b1;
  end

  // mstatus update values; mret data is needed on the accept cycle so it uses the live CSR value.
  always_comb begin
    trap_status        = mstatus_q;
    trap_status[7]     = mstatus_q[3];
    trap_status[3]     = 1'b0;
    trap_status[12:11] = 2'b11;

    mret_status        = mstatus_i;
    mret_status[3]     = mstatus_i[7];
    mret_status[7]     = 1'b1;
    mret_status[12:11] = MRET_MPP;
  end

  always_comb begin
    trap_target = {mtvec_q[XLEN-1:2], 2'b00};
`ifdef CSR_TRAP_VECTORED_EN
    if (cause_q[XLEN-1] && (mtvec_q[1:0] == 2'b01))
      trap_target = {mtvec_q[XLEN-1:2], 2'b00} + {{(XLEN-6){1'b0}}, cause_q[3:0], 2'b00};
`endif
  end

  assign unused_bits = ^{mie_i, mtvec_q[1:0]};

  // Outputs are registered: each branch loads the values that belong to the state being entered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      cause_q        <= '0;
      tval_q         <= '0;
      mstatus_q      <= '0;
      mtvec_q        <= '0;
      mepc_q         <= '0;
      csr_we         <= 1'b0;
      csr_waddr      <= '0;
      csr_wdata      <= '0;
      stall          <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
    end else begin
      csr_we         <= 1'b0;
      csr_waddr      <= '0;
      csr_wdata      <= '0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      stall          <= 1'b1;
      case (state)
        IDLE: begin
          if (accept_exc || accept_int) begin
            state     <= W_MEPC;
            cause_q   <= accept_exc ? exc_cause : int_cause;
            tval_q    <= accept_exc ? commit_tval : '0;
            mstatus_q <= mstatus_i;
            mtvec_q   <= mtvec_i;
            mepc_q    <= mepc_i;
            csr_we    <= 1'b1;
            csr_waddr <= ADDR_MEPC;
            csr_wdata <= commit_pc;
          end else if (accept_mret) begin
            state     <= M_STATUS;
            mstatus_q <= mstatus_i;
            mtvec_q   <= mtvec_i;
            mepc_q    <= mepc_i;
            csr_we    <= 1'b1;
            csr_waddr <= ADDR_MSTATUS;
            csr_wdata <= mret_status;
          end else begin
            stall <= 1'b0;
          end
        end
        W_MEPC: begin
          state     <= W_MCAUSE;
          csr_we    <= 1'b1;
          csr_waddr <= ADDR_MCAUSE;
          csr_wdata <= cause_q;
        end
        W_MCAUSE: begin
          state     <= W_MTVAL;
          csr_we    <= 1'b1;
          csr_waddr <= ADDR_MTVAL;
          csr_wdata <= tval_q;
        end
        W_MTVAL: begin
          state     <= W_MSTATUS;
          csr_we    <= 1'b1;
          csr_waddr <= ADDR_MSTATUS;
          csr_wdata <= trap_status;
        end
        W_MSTATUS: begin
          state          <= REDIRECT;
          redirect_valid <= 1'b1;
          redirect_pc    <= trap_target;
        end
        M_STATUS: begin
          state          <= REDIRECT;
          redirect_valid <= 1'b1;
          redirect_pc    <= mepc_q;
        end
        REDIRECT: begin
          state <= IDLE;
          stall <= 1'b0;
        end
        default: begin
          state <= IDLE;
          stall <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_csr_trap_ctrl.sv
// Bench for csr_trap_ctrl: directed literal scenarios plus randomized traffic against a plan-queue reference model.
// Honours CSR_TRAP_VECTORED_EN for the expected vectored redirect target.
module tb_csr_trap_ctrl;

  localparam logic [63:0] MRET_MPP_W = 64'd0;

  logic        clk = 1'b0;
  logic        reset;
  logic        commit_valid, commit_exc, commit_mret;
  logic [63:0] commit_pc, commit_tval;
  logic [3:0]  commit_cause;
  logic        trint, swint, exint;
  logic [63:0] mstatus_i, mie_i, mtvec_i, mepc_i;
  logic        csr_we, stall, redirect_valid;
  logic [11:0] csr_waddr;
  logic [63:0] csr_wdata, redirect_pc;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  csr_trap_ctrl #(.XLEN(64), .EXC_W(4), .MRET_MPP(2'b00)) dut (
    .clk(clk), .reset(reset),
    .commit_valid(commit_valid), .commit_pc(commit_pc), .commit_exc(commit_exc),
    .commit_cause(commit_cause), .commit_tval(commit_tval), .commit_mret(commit_mret),
    .trint(trint), .swint(swint), .exint(exint),
    .mstatus_i(mstatus_i), .mie_i(mie_i), .mtvec_i(mtvec_i), .mepc_i(mepc_i),
    .csr_we(csr_we), .csr_waddr(csr_waddr), .csr_wdata(csr_wdata), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  typedef struct packed {
    logic        we;
    logic [11:0] addr;
    logic [63:0] data;
    logic        stl;
    logic        rv;
    logic [63:0] rpc;
  } out_t;

  out_t plan[$];
  out_t exp_o = '0;
  bit   model_ok = 1'b0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp)
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    else
      passes++;
  endtask

  function automatic out_t mk(input logic we, input logic [11:0] a, input logic [63:0] d,
                              input logic st, input logic rv, input logic [63:0] rpc);
    out_t o;
    o.we = we; o.addr = a; o.data = d; o.stl = st; o.rv = rv; o.rpc = rpc;
    return o;
  endfunction

  // Reference: on an accepted event, queue the whole cycle-by-cycle output script up front.
  function automatic void planAccept();
    logic [63:0] cause, tval, target, code;
    logic        is_int;
    is_int = 1'b0;
    code   = 64'd0;
    if (!commit_valid) return;
    if (!commit_exc && commit_mret) begin
      plan.push_back(mk(1, 12'h300, (mstatus_i & ~64'h1888) | ((mstatus_i >> 4) & 64'h8)
                        | 64'h80 | (MRET_MPP_W << 11), 1, 0, 0));
      plan.push_back(mk(0, 0, 0, 1, 1, mepc_i));
      plan.push_back(mk(0, 0, 0, 0, 0, 0));
      return;
    end
    if (commit_exc) begin
      cause = {60'd0, commit_cause};
      tval  = commit_tval;
    end else begin
      if (exint && mie_i[11])      code = 11;
      else if (swint && mie_i[3])  code = 3;
      else if (trint && mie_i[7])  code = 7;
      if (code == 0 || !mstatus_i[3]) return;
      is_int = 1'b1;
      cause  = (64'd1 << 63) | code;
      tval   = 0;
    end
    target = mtvec_i & ~64'd3;
`ifdef CSR_TRAP_VECTORED_EN
    if (is_int && mtvec_i[1:0] == 2'b01) target = target + 4 * code;
`endif
    plan.push_back(mk(1, 12'h341, commit_pc, 1, 0, 0));
    plan.push_back(mk(1, 12'h342, cause, 1, 0, 0));
    plan.push_back(mk(1, 12'h343, tval, 1, 0, 0));
    plan.push_back(mk(1, 12'h300, (mstatus_i & ~64'h1888) | ((mstatus_i & 64'h8) << 4) | 64'h1800, 1, 0, 0));
    plan.push_back(mk(0, 0, 0, 1, 1, target));
    plan.push_back(mk(0, 0, 0, 0, 0, 0));
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      plan.delete();
      exp_o    = '0;
      model_ok = 1'b1;
    end else if (model_ok) begin
      if (plan.size() == 0) planAccept();
      exp_o = (plan.size() > 0) ? plan.pop_front() : '0;
    end
  end

  always @(negedge clk) begin
    if (model_ok) begin
      checkOutput("m_csr_we", {63'd0, csr_we}, {63'd0, exp_o.we});
      checkOutput("m_csr_waddr", {52'd0, csr_waddr}, {52'd0, exp_o.addr});
      checkOutput("m_csr_wdata", csr_wdata, exp_o.data);
      checkOutput("m_stall", {63'd0, stall}, {63'd0, exp_o.stl});
      checkOutput("m_redirect_valid", {63'd0, redirect_valid}, {63'd0, exp_o.rv});
      checkOutput("m_redirect_pc", redirect_pc, exp_o.rpc);
    end
  end

  task automatic applyStimulus(input logic cv, input logic exc, input logic [3:0] cause,
                               input logic mret, input logic [63:0] pc, input logic [63:0] tval,
                               input logic [63:0] ms, input logic [63:0] mie, input logic [63:0] mtvec,
                               input logic [63:0] mepc, input logic ti, input logic si, input logic ei);
    commit_valid = cv; commit_exc = exc; commit_cause = cause; commit_mret = mret;
    commit_pc = pc; commit_tval = tval; mstatus_i = ms; mie_i = mie; mtvec_i = mtvec;
    mepc_i = mepc; trint = ti; swint = si; exint = ei;
    @(posedge clk); #2;
  endtask

  task automatic idleCycle();
    commit_valid = 1'b0; commit_exc = 1'b0; commit_mret = 1'b0;
    trint = 1'b0; swint = 1'b0; exint = 1'b0;
    @(posedge clk); #2;
  endtask

  task automatic checkWrite(input string name, input logic [11:0] a, input logic [63:0] d);
    checkOutput({name, "_we"}, {63'd0, csr_we}, 64'd1);
    checkOutput({name, "_addr"}, {52'd0, csr_waddr}, {52'd0, a});
    checkOutput({name, "_data"}, csr_wdata, d);
    checkOutput({name, "_stall"}, {63'd0, stall}, 64'd1);
  endtask

  task automatic checkQuiet(input string name);
    checkOutput({name, "_we"}, {63'd0, csr_we}, 64'd0);
    checkOutput({name, "_stall"}, {63'd0, stall}, 64'd0);
    checkOutput({name, "_rv"}, {63'd0, redirect_valid}, 64'd0);
  endtask

  initial begin
    reset = 1'b1;
    commit_valid = 0; commit_exc = 0; commit_mret = 0; commit_cause = 0;
    commit_pc = 0; commit_tval = 0; trint = 0; swint = 0; exint = 0;
    mstatus_i = 0; mie_i = 0; mtvec_i = 0; mepc_i = 0;
    repeat (2) @(posedge clk);
    #2;
    checkQuiet("reset");
    checkOutput("reset_wdata", csr_wdata, 64'd0);
    reset = 1'b0;

    // Exception with full 5-cycle sequence
    applyStimulus(1, 1, 4'd2, 0, 64'h8000_0040, 64'hdead, 64'h8, 64'h0, 64'h8000_0100, 64'h0, 0, 0, 0);
    checkWrite("exc_mepc", 12'h341, 64'h8000_0040);
    idleCycle(); checkWrite("exc_mcause", 12'h342, 64'd2);
    idleCycle(); checkWrite("exc_mtval", 12'h343, 64'hdead);
    idleCycle(); checkWrite("exc_mstatus", 12'h300, 64'h1880);
    idleCycle();
    checkOutput("exc_rv", {63'd0, redirect_valid}, 64'd1);
    checkOutput("exc_rpc", redirect_pc, 64'h8000_0100);
    checkOutput("exc_rd_stall", {63'd0, stall}, 64'd1);
    checkOutput("exc_rd_we", {63'd0, csr_we}, 64'd0);
    idleCycle(); checkQuiet("exc_done");

    // Interrupt priority: external over timer
    applyStimulus(1, 0, 0, 0, 64'h8000_0200, 64'h55, 64'h8, 64'h888, 64'h8000_0100, 0, 1, 0, 1);
    checkWrite("int_mepc", 12'h341, 64'h8000_0200);
    idleCycle(); checkWrite("int_mcause", 12'h342, 64'h8000_0000_0000_000b);
    idleCycle(); checkWrite("int_mtval", 12'h343, 64'd0);
    idleCycle(); idleCycle(); idleCycle();
    applyStimulus(1, 0, 0, 0, 64'h8000_0200, 0, 64'h0, 64'h888, 64'h8000_0100, 0, 1, 0, 1);
    checkQuiet("int_mie0");
    idleCycle(); checkQuiet("int_mie0_b");

    // mret
    applyStimulus(1, 0, 0, 1, 64'h8000_0300, 0, 64'h1880, 0, 64'h8000_0100, 64'h8000_0044, 0, 0, 0);
    checkWrite("mret_mstatus", 12'h300, 64'h88);
    idleCycle();
    checkOutput("mret_rv", {63'd0, redirect_valid}, 64'd1);
    checkOutput("mret_rpc", redirect_pc, 64'h8000_0044);
    idleCycle(); checkQuiet("mret_done");

    // Simultaneous exc+mret, commits held during stall
    applyStimulus(1, 1, 4'd5, 1, 64'h8000_0400, 64'h77, 64'h8, 0, 64'h8000_0100, 64'h8000_0044, 0, 0, 0);
    checkWrite("sim_mepc", 12'h341, 64'h8000_0400);
    applyStimulus(1, 1, 4'd6, 1, 64'h1, 64'h2, 64'h8, 0, 64'h9000_0000, 64'h3, 0, 0, 0);
    checkWrite("sim_mcause", 12'h342, 64'd5);
    applyStimulus(1, 1, 4'd6, 1, 64'h1, 64'h2, 64'h8, 0, 64'h9000_0000, 64'h3, 0, 0, 0);
    applyStimulus(1, 1, 4'd6, 1, 64'h1, 64'h2, 64'h8, 0, 64'h9000_0000, 64'h3, 0, 0, 0);
    checkWrite("sim_mstatus", 12'h300, 64'h1880);
    applyStimulus(1, 1, 4'd6, 1, 64'h1, 64'h2, 64'h8, 0, 64'h9000_0000, 64'h3, 0, 0, 0);
    checkOutput("sim_rpc", redirect_pc, 64'h8000_0100);
    idleCycle(); checkQuiet("sim_done");
    idleCycle(); checkQuiet("sim_done_b");

    // Reset while writing mtval
    applyStimulus(1, 1, 4'd1, 0, 64'h8000_0500, 64'h9, 64'h8, 0, 64'h8000_0100, 0, 0, 0, 0);
    idleCycle(); idleCycle();
    checkWrite("rst_mtval", 12'h343, 64'h9);
    reset = 1'b1;
    @(posedge clk); #2;
    checkQuiet("rst_abort");
    reset = 1'b0;
    repeat (4) begin
      idleCycle(); checkQuiet("rst_after");
    end

    // Vectored timer interrupt
    applyStimulus(1, 0, 0, 0, 64'h8000_0600, 0, 64'h8, 64'h80, 64'h8000_0101, 0, 1, 0, 0);
    idleCycle(); checkWrite("vec_mcause", 12'h342, 64'h8000_0000_0000_0007);
    idleCycle(); idleCycle(); idleCycle();
    checkOutput("vec_rv", {63'd0, redirect_valid}, 64'd1);
`ifdef CSR_TRAP_VECTORED_EN
    checkOutput("vec_rpc", redirect_pc, 64'h8000_011c);
`else
    checkOutput("vec_rpc", redirect_pc, 64'h8000_0100);
`endif
    idleCycle();

    // Randomized traffic; the per-cycle compare process does the checking
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(0, 99) == 0);
      applyStimulus($urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0, 4'($urandom_range(0, 15)),
                    $urandom_range(0, 3) == 0, {$urandom, $urandom}, {$urandom, $urandom},
                    {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom} & ~64'd2,
                    {$urandom, $urandom}, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                    $urandom_range(0, 1) == 1);
    end
    reset = 1'b0;
    repeat (8) idleCycle();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/csr_trap_ctrl.md
Name: csr_trap_ctrl

Overview:
- Machine-mode trap sequencer sitting between the commit stage and the CSR file's single write port.
- On a committing exception, a pending enabled interrupt, or an mret, it stalls the pipeline and writes mepc/mcause/mtval/mstatus one CSR per cycle.
- It then issues a single-cycle PC redirect to the handler or return address.

Parameters:
- XLEN, 64, CSR/PC data width.
- EXC_W, 4, width of synchronous exception code from commit.
- MRET_MPP, 2'b00, value written to mstatus.MPP on mret.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- commit_valid  in  1  an instruction is committing this cycle
- commit_pc  in  XLEN  PC of the committing instruction
- commit_exc  in  1  committing instruction raised an exception
- commit_cause  in  EXC_W  exception code
- commit_tval  in  XLEN  exception trap value
- commit_mret  in  1  committing instruction is mret
- trint / swint / exint  in  1 each  timer / software / external interrupt lines
- mstatus_i, mie_i, mtvec_i, mepc_i  in  XLEN each  current CSR values
- csr_we  out  1  CSR write strobe
- csr_waddr  out  12  CSR address
- csr_wdata  out  XLEN  CSR write data
- stall  out  1  hold the pipeline; no commits accepted
- redirect_valid  out  1  one-cycle PC redirect
- redirect_pc  out  XLEN  redirect target

Behaviour:
- Reset: state=IDLE; all outputs 0; latched registers 0. A reset mid-sequence aborts it with no further writes.
- Interrupt pending: pend_e=exint&mie[11], pend_s=swint&mie[3], pend_t=trint&mie[7]; each is taken only if mstatus_i[3] (MIE)=1.
- Accept rule: in IDLE with commit_valid=1, exactly one event is accepted, in priority order:
  - commit_exc
  - commit_mret
  - interrupt (external code 11 > software 3 > timer 7)
- Interrupt accept: the committing instruction is squashed and mepc=commit_pc.
- Latch on accept: pc, cause word, tval, mstatus_i, mtvec_i, mepc_i.
  - Exception: cause={0, commit_cause}, tval=commit_tval.
  - Interrupt: cause={1'b1, 59'b0, code}, tval=0.
- Trap FSM:
  - IDLE -> W_MEPC -> W_MCAUSE -> W_MTVAL -> W_MSTATUS -> REDIRECT -> IDLE.
  - One csr_we pulse per write state, with addresses 0x341, 0x342, 0x343, 0x300.
  - W_MSTATUS data = latched mstatus with MPIE(bit7)=old MIE, MIE(bit3)=0, MPP[12:11]=2'b11.
- Mret FSM: IDLE -> M_STATUS (addr 0x300, data: MIE=old MPIE, MPIE=1, MPP=MRET_MPP) -> REDIRECT -> IDLE.
- REDIRECT: redirect_valid=1 for exactly one cycle, csr_we=0.
  - Trap target = {mtvec[XLEN-1:2], 2'b00}.
  - Mret target = latched mepc_i.
- stall is registered: 1 in every non-IDLE state, 0 in IDLE. The accept cycle itself has stall=0 because the commit is already occurring.
- Latency: trap accept-to-redirect is 5 cycles; mret is 2 cycles. The next accept is possible in the cycle after REDIRECT.
- Commit inputs are ignored while not in IDLE.
- Interrupts arriving mid-sequence are not latched; they are re-evaluated at the next IDLE commit, where mstatus.MIE is now 0.
- csr_waddr/csr_wdata are 0 whenever csr_we=0.
- Simultaneous commit_exc and commit_mret: exception wins and mret is dropped.

Optional Feature:
- Macro CSR_TRAP_VECTORED_EN.
- Defined: if mtvec[1:0]==2'b01 and the event is an interrupt, trap target = base + 4*code. Exceptions always go to base.
- Undefined: mtvec[1:0] ignored; all traps go to base.

Test Plan:
- Exception: mtvec=0x8000_0100, commit_pc=0x8000_0040, exc cause 2, tval=0xdead, mstatus=0x8 -> writes mepc=0x8000_0040, mcause=2, mtval=0xdead, mstatus=0x1880; redirect 0x8000_0100 on the 5th cycle; stall high for cycles 1-5.
- Interrupt priority: exint=trint=1, mie=0x888, MIE=1 -> mcause=0x8000_0000_0000_000b, mtval=0. With MIE=0 -> no accept, stall stays 0.
- Mret: mstatus=0x1880, mepc=0x8000_0044 -> writes mstatus=0x88 with MRET_MPP=0; redirect 0x8000_0044 on cycle 2.
- Simultaneous exc and mret, plus commits asserted during stall -> only the exception sequence runs; no extra writes.
- Reset asserted in W_MTVAL -> next cycle: state IDLE, csr_we=0, stall=0, no redirect.
- Vectored mtvec=0x8000_0101, timer interrupt -> redirect 0x8000_011c with CSR_TRAP_VECTORED_EN defined, 0x8000_0100 without.
